serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 5 +
 rtl/serial_adder_full_adder.sv | 11 +
 rtl/serial_adder.sv | 74 +++++++
 tb/tb_serial_adder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default width for the bit-serial adder.
package serial_adder_pkg;
   localparam int DEFAULT_WIDTH = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: 1-bit full adder used for the per-bit serial step.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock, registered sum/cout/ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
   logic carry, bit_sum, bit_cout, last;
   full_adder u_fa (
      .a   (op_a[0]),
      .b   (op_b[0]),
      .cin (carry),
      .sum (bit_sum),
      .cout(bit_cout)
   );
   assign last    = cnt == CW'(WIDTH - 1);
   assign res_nxt = (res >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      state_nxt = (state == IDLE && start) ? RUN  :
                  (state == RUN  && last)  ? DONE :
                  (state == DONE)          ? IDLE : state;
      busy      = state != IDLE;
      done      = state == DONE;
   end
   // carry still holds the carry into the MSB on the last RUN edge, which gives ovf
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (state == IDLE && start) begin
         op_a  <= a;
         op_b  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         res   <= res_nxt;
         op_a  <= op_a >> 1;
         op_b  <= op_b >> 1;
         carry <= bit_cout;
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum  <= res_nxt;
            cout <= bit_cout;
            ovf  <= carry ^ bit_cout;
         end
      end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=4.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [3:0] a = '0, b = '0;
   logic cin = 1'b0;
   logic busy, done, cout, ovf;
   logic [3:0] sum;
   int ncmp = 0, nerr = 0;

   serial_adder #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
      ncmp++; if ({sum, cout, ovf} !== 6'b0) begin nerr++; $display("FAIL reset_result got %b want 000000", {sum, cout, ovf}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                           input logic [3:0] es, input logic ec, input logic eo, input string nm);
      int n;
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
      n = 0;
      while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      ncmp++; if (n != 4) begin nerr++; $display("FAIL %s_latency got %0d want 4", nm, n); end
      ncmp++; if (sum !== es) begin nerr++; $display("FAIL %s_sum got %b want %b", nm, sum, es); end
      ncmp++; if (cout !== ec) begin nerr++; $display("FAIL %s_cout got %b want %b", nm, cout, ec); end
      ncmp++; if (ovf !== eo) begin nerr++; $display("FAIL %s_ovf got %b want %b", nm, ovf, eo); end
      @(negedge clk);
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL %s_done_pulse got %b want 0", nm, done); end
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL %s_idle_busy got %b want 0", nm, busy); end
      ncmp++; if (sum !== es) begin nerr++; $display("FAIL %s_sum_hold got %b want %b", nm, sum, es); end
   endtask

   task automatic test_ignore_start();
      int dn;
      logic [3:0] s_seen;
      logic c_seen;
      @(negedge clk);
      a = 4'b0010; b = 4'b0001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 4'b1111; b = 4'b1111; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ncmp++; if (busy !== 1'b1) begin nerr++; $display("FAIL ignore_busy got %b want 1", busy); end
      ncmp++; if (sum !== 4'b1111) begin nerr++; $display("FAIL ignore_sum_hold got %b want 1111", sum); end
      dn = 0; s_seen = 'x; c_seen = 1'bx;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) begin dn++; s_seen = sum; c_seen = cout; end
      end
      ncmp++; if (dn != 1) begin nerr++; $display("FAIL ignore_done_count got %0d want 1", dn); end
      ncmp++; if (s_seen !== 4'b0011) begin nerr++; $display("FAIL ignore_sum got %b want 0011", s_seen); end
      ncmp++; if (c_seen !== 1'b0) begin nerr++; $display("FAIL ignore_cout got %b want 0", c_seen); end
   endtask

   task automatic test_reset_mid_run();
      int dn;
      @(negedge clk);
      a = 4'b0110; b = 4'b0011; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b want 0", busy); end
      ncmp++; if (sum !== 4'b0000) begin nerr++; $display("FAIL midrst_sum got %b want 0000", sum); end
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL midrst_done got %b want 0", done); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (8) begin @(negedge clk); if (done !== 1'b0) dn++; end
      ncmp++; if (dn != 0) begin nerr++; $display("FAIL midrst_no_done got %0d pulses want 0", dn); end
      test_add(4'b0100, 4'b0100, 1'b0, 4'b1000, 1'b0, 1'b1, "post_reset");
   endtask

   task automatic test_back_to_back();
      logic [3:0] oa [5] = '{4'b0011, 4'b1111, 4'b0111, 4'b1000, 4'b1010};
      logic [3:0] ob [5] = '{4'b0101, 4'b0001, 4'b0111, 4'b1000, 4'b0101};
      logic       oc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [4:0] full;
      logic eo;
      int idx, cyc, last_cyc, low;
      @(negedge clk);
      a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
      idx = 0; cyc = 0; last_cyc = 0; low = 0;
      while (idx < 5 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (busy === 1'b0) low++;
         if (done === 1'b1) begin
            full = 5'(oa[idx]) + 5'(ob[idx]) + 5'(oc[idx]);
            eo = (oa[idx][3] == ob[idx][3]) && (full[3] != oa[idx][3]);
            ncmp++; if (sum !== full[3:0]) begin nerr++; $display("FAIL b2b%0d_sum got %b want %b", idx, sum, full[3:0]); end
            ncmp++; if (cout !== full[4]) begin nerr++; $display("FAIL b2b%0d_cout got %b want %b", idx, cout, full[4]); end
            ncmp++; if (ovf !== eo) begin nerr++; $display("FAIL b2b%0d_ovf got %b want %b", idx, ovf, eo); end
            if (idx > 0) begin
               ncmp++; if (cyc - last_cyc != 6) begin nerr++; $display("FAIL b2b%0d_period got %0d want 6", idx, cyc - last_cyc); end
               ncmp++; if (low != 1) begin nerr++; $display("FAIL b2b%0d_idle_gap got %0d want 1", idx, low); end
            end
            low = 0; last_cyc = cyc; idx++;
            if (idx < 5) begin a = oa[idx]; b = ob[idx]; cin = oc[idx]; end
         end
      end
      start = 1'b0;
      ncmp++; if (idx != 5) begin nerr++; $display("FAIL b2b_completed got %0d want 5", idx); end
      repeat (8) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1, "add_pos_ovf");
      test_add(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "add_wrap");
      test_add(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, "add_cin");
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
